// File: rtl/mmu_sequencer.sv
// mmu_sequencer: runs one weight-stationary matrix-multiply pass.
// The optional weight load goes WB -> weight FIFO -> MMU. Activations then go
// UB -> data FIFO -> MMU, and results are written to the accumulator.
// Every output is registered. Each output register loads a value decoded from
// the next state and next phase count, so the outputs line up with the state
// the sequencer enters on that edge.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | waiting for start; all strobes low
// S_LOAD_W  | ARRAY_DIM WB reads of the weight tile
// S_W_FLUSH | BRAM + weight FIFO drain into the MMU weight registers
// S_COMPUTE | rows UB reads of activations
// S_C_DRAIN | pipeline drain; accumulator writes near the end
// S_DONE    | one-cycle completion pulse
module mmu_sequencer #(
  parameter int ARRAY_DIM  = 16,
  parameter int ADDR_WIDTH = 8,
  parameter int BRAM_LAT   = 1,
  parameter int FIFO_DEPTH = 4,
  parameter int MMU_LAT    = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  load_w,
  input  logic                  accumulate,
  input  logic [ADDR_WIDTH-1:0] wb_base,
  input  logic [ADDR_WIDTH-1:0] ub_base,
  input  logic [ADDR_WIDTH-1:0] acc_base,
  input  logic [ADDR_WIDTH-1:0] rows,
  output logic                  read_wb,
  output logic                  read_ub,
  output logic [ADDR_WIDTH-1:0] addrb,
  output logic                  weight_fifo_en,
  output logic                  mmu_load_weight_en,
  output logic                  data_fifo_en,
  output logic                  mm_en,
  output logic                  write_acc,
  output logic                  acc_en,
  output logic [ADDR_WIDTH-1:0] addra,
  output logic                  busy,
  output logic                  done
);

  // FILL: cycles from a BRAM read until the data leaves the FIFO.
  // LAT: cycles from a UB read until its MMU result is ready to write.
  localparam int FILL = BRAM_LAT + FIFO_DEPTH;
  localparam int LAT  = FILL + MMU_LAT;
  // The phase counter keeps running from the first COMPUTE cycle to the last
  // write, so it must hold the largest rows value plus LAT.
  localparam int CW   = $clog2((1 << ADDR_WIDTH) + ARRAY_DIM + LAT + 2);
  typedef logic [CW-1:0] cnt_t;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_W, S_W_FLUSH, S_COMPUTE, S_C_DRAIN, S_DONE
  } state_t;

  state_t state, nxt_state;
  cnt_t   pc, nxt_pc, g, rx;
  logic [ADDR_WIDTH-1:0] wb_q, ub_q, acc_q, rows_q;
  logic [ADDR_WIDTH-1:0] nxt_wb, nxt_ub, nxt_acc, nxt_rows;
  logic accum_q, nxt_accum;

  logic d_read_wb, d_read_ub, d_wfe, d_mlw, d_dfe, d_mm, d_wacc, d_acc_en, d_busy, d_done;
  logic [ADDR_WIDTH-1:0] d_addrb, d_addra;

  // Next state, phase counter and launch-parameter capture.
  always_comb begin
    nxt_state = state;
    nxt_pc    = pc + cnt_t'(1);
    nxt_wb    = wb_q;
    nxt_ub    = ub_q;
    nxt_acc   = acc_q;
    nxt_rows  = rows_q;
    nxt_accum = accum_q;
    case (state)
      S_IDLE: begin
        nxt_pc = '0;
        if (start) begin
          nxt_wb    = wb_base;
          nxt_ub    = ub_base;
          nxt_acc   = acc_base;
          nxt_rows  = rows;
          nxt_accum = accumulate;
          if (load_w)            nxt_state = S_LOAD_W;
          else if (rows != '0)   nxt_state = S_COMPUTE;
          else                   nxt_state = S_DONE;
        end
      end
      S_LOAD_W: begin
        if (pc == cnt_t'(ARRAY_DIM - 1)) begin
          nxt_state = S_W_FLUSH;
          nxt_pc    = '0;
        end
      end
      S_W_FLUSH: begin
        if (pc == cnt_t'(FILL - 1)) begin
          nxt_pc    = '0;
          nxt_state = (rows_q != '0) ? S_COMPUTE : S_DONE;
        end
      end
      S_COMPUTE: begin
        if (pc == cnt_t'(rows_q) - cnt_t'(1)) nxt_state = S_C_DRAIN;
      end
      S_C_DRAIN: begin
        if (pc == cnt_t'(rows_q) + cnt_t'(LAT - 1)) begin
          nxt_state = S_DONE;
          nxt_pc    = '0;
        end
      end
      S_DONE: begin
        nxt_state = S_IDLE;
        nxt_pc    = '0;
      end
      default: begin
        nxt_state = S_IDLE;
        nxt_pc    = '0;
      end
    endcase
  end

  // Decode the strobes for the cycle being entered.
  always_comb begin
    d_read_wb = 1'b0;
    d_read_ub = 1'b0;
    d_addrb   = '0;
    d_wfe     = 1'b0;
    d_mlw     = 1'b0;
    d_dfe     = 1'b0;
    d_mm      = 1'b0;
    d_wacc    = 1'b0;
    d_acc_en  = 1'b0;
    d_addra   = '0;
    g         = '0;
    rx        = cnt_t'(nxt_rows);
    case (nxt_state)
      S_LOAD_W, S_W_FLUSH: begin
        // g = cycles since the first WB read, counted across both phases.
        g = (nxt_state == S_W_FLUSH) ? nxt_pc + cnt_t'(ARRAY_DIM) : nxt_pc;
        if (nxt_state == S_LOAD_W) begin
          d_read_wb = 1'b1;
          d_addrb   = nxt_wb + ADDR_WIDTH'(nxt_pc);
        end
        d_wfe = (g >= cnt_t'(BRAM_LAT));
        d_mlw = (g >= cnt_t'(FILL));
      end
      S_COMPUTE, S_C_DRAIN: begin
        if (nxt_state == S_COMPUTE) begin
          d_read_ub = 1'b1;
          d_addrb   = nxt_ub + ADDR_WIDTH'(nxt_pc);
        end
        d_dfe = (nxt_pc >= cnt_t'(BRAM_LAT)) && (nxt_pc < rx + cnt_t'(FILL));
        d_mm  = (nxt_pc >= cnt_t'(FILL)) && (nxt_pc < rx + cnt_t'(LAT));
        if ((nxt_pc >= cnt_t'(LAT)) && (nxt_pc < rx + cnt_t'(LAT))) begin
          d_wacc   = 1'b1;
          d_acc_en = nxt_accum;
          d_addra  = nxt_acc + ADDR_WIDTH'(nxt_pc - cnt_t'(LAT));
        end
      end
      default: ;
    endcase
    d_busy = (nxt_state != S_IDLE);
    d_done = (nxt_state == S_DONE);
  end

  // State, captured parameters and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state              <= S_IDLE;
      pc                 <= '0;
      wb_q               <= '0;
      ub_q               <= '0;
      acc_q              <= '0;
      rows_q             <= '0;
      accum_q            <= 1'b0;
      read_wb            <= 1'b0;
      read_ub            <= 1'b0;
      addrb              <= '0;
      weight_fifo_en     <= 1'b0;
      mmu_load_weight_en <= 1'b0;
      data_fifo_en       <= 1'b0;
      mm_en              <= 1'b0;
      write_acc          <= 1'b0;
      acc_en             <= 1'b0;
      addra              <= '0;
      busy               <= 1'b0;
      done               <= 1'b0;
    end else begin
      state              <= nxt_state;
      pc                 <= nxt_pc;
      wb_q               <= nxt_wb;
      ub_q               <= nxt_ub;
      acc_q              <= nxt_acc;
      rows_q             <= nxt_rows;
      accum_q            <= nxt_accum;
      read_wb            <= d_read_wb;
      read_ub            <= d_read_ub;
      addrb              <= d_addrb;
      weight_fifo_en     <= d_wfe;
      mmu_load_weight_en <= d_mlw;
      data_fifo_en       <= d_dfe;
      mm_en              <= d_mm;
      write_acc          <= d_wacc;
      acc_en             <= d_acc_en;
      addra              <= d_addra;
      busy               <= d_busy;
      done               <= d_done;
    end
  end

endmodule

// File: tb/tb_mmu_sequencer.sv
// Testbench for mmu_sequencer. Expected outputs are worked out per cycle from
// the pass timeline, counted from the start-accept edge.
module tb_mmu_sequencer;
  localparam int AD = 16, BL = 1, FD = 4, ML = 32;

  logic clk = 1'b0;
  logic reset_n, start, load_w, accumulate;
  logic [7:0] wb_base, ub_base, acc_base, rows;
  logic read_wb, read_ub, weight_fifo_en, mmu_load_weight_en, data_fifo_en;
  logic mm_en, write_acc, acc_en, busy, done;
  logic [7:0] addrb, addra;

  always #5 clk = ~clk;

  mmu_sequencer dut (
    .clk(clk), .reset_n(reset_n), .start(start), .load_w(load_w),
    .accumulate(accumulate), .wb_base(wb_base), .ub_base(ub_base),
    .acc_base(acc_base), .rows(rows), .read_wb(read_wb), .read_ub(read_ub),
    .addrb(addrb), .weight_fifo_en(weight_fifo_en),
    .mmu_load_weight_en(mmu_load_weight_en), .data_fifo_en(data_fifo_en),
    .mm_en(mm_en), .write_acc(write_acc), .acc_en(acc_en), .addra(addra),
    .busy(busy), .done(done)
  );

  typedef struct packed {
    logic read_wb, read_ub;
    logic [7:0] addrb;
    logic wfe, mlw, dfe, mm, wacc, acc_en;
    logic [7:0] addra;
    logic busy, done;
  } out_t;

  out_t act;
  assign act = {read_wb, read_ub, addrb, weight_fifo_en, mmu_load_weight_en,
                data_fifo_en, mm_en, write_acc, acc_en, addra, busy, done};

  typedef struct {
    bit lw, ac;
    logic [7:0] wb, ub, ab, rows;
  } txn_t;

  typedef struct {
    txn_t t;
    int done_k, first_wacc, n_wb, n_load, n_mm, n_wacc;
    logic [7:0] last_addra;
  } vec_t;

  int n_cmp = 0, n_bad = 0;
  int o_done_k, o_first_wacc, o_nwb, o_nload, o_nmm, o_nwacc, o_ndone;
  logic [7:0] o_last_addra;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic int model_done(txn_t t);
    int s = 1 + (t.lw ? AD + BL + FD : 0);
    return (t.rows != 0) ? s + BL + FD + ML + int'(t.rows) : s;
  endfunction

  // Expected outputs in cycle k after the start-accept edge (k=1 is the first busy cycle).
  function automatic out_t model(int k, txn_t t);
    out_t o = '0;
    int s, w, r, dk;
    r = int'(t.rows);
    s = 1 + (t.lw ? AD + BL + FD : 0);
    w = s + BL + FD + ML;
    if (t.lw && k >= 1 && k <= AD) begin
      o.read_wb = 1'b1;
      o.addrb   = t.wb + 8'(k - 1);
    end
    if (t.lw && k >= 1 + BL && k <= BL + AD + FD) o.wfe = 1'b1;
    if (t.lw && k >= 1 + BL + FD && k <= BL + AD + FD) o.mlw = 1'b1;
    if (r > 0) begin
      if (k >= s && k < s + r) begin
        o.read_ub = 1'b1;
        o.addrb   = t.ub + 8'(k - s);
      end
      if (k >= s + BL && k < s + BL + r + FD) o.dfe = 1'b1;
      if (k >= s + BL + FD && k < w + r) o.mm = 1'b1;
      if (k >= w && k < w + r) begin
        o.wacc   = 1'b1;
        o.acc_en = t.ac;
        o.addra  = t.ab + 8'(k - w);
      end
    end
    dk = model_done(t);
    o.busy = (k >= 1 && k <= dk);
    o.done = (k == dk);
    return o;
  endfunction

  task automatic launch(input txn_t t);
    @(negedge clk);
    start = 1'b1; load_w = t.lw; accumulate = t.ac;
    wb_base = t.wb; ub_base = t.ub; acc_base = t.ab; rows = t.rows;
  endtask

  // Run a full pass; repulse_k>0 pulses start again in that cycle, scramble
  // changes the launch inputs while the pass is running.
  task automatic run_pass(input txn_t t, input int repulse_k, input bit scramble);
    int dk;
    dk = model_done(t);
    o_done_k = 0; o_first_wacc = 0; o_nwb = 0; o_nload = 0; o_nmm = 0;
    o_nwacc = 0; o_ndone = 0; o_last_addra = '0;
    launch(t);
    for (int k = 1; k <= dk + 2; k++) begin
      @(negedge clk);
      start = (k == repulse_k);
      if (scramble) begin
        load_w = 1'($urandom); accumulate = 1'($urandom);
        wb_base = 8'($urandom); ub_base = 8'($urandom);
        acc_base = 8'($urandom); rows = 8'($urandom);
      end
      chk($sformatf("cyc%0d", k), act, model(k, t));
      if (done) begin o_ndone++; o_done_k = k; end
      if (write_acc) begin
        if (o_first_wacc == 0) o_first_wacc = k;
        o_nwacc++;
        o_last_addra = addra;
      end
      if (read_wb) o_nwb++;
      if (mmu_load_weight_en) o_nload++;
      if (mm_en) o_nmm++;
    end
    start = 1'b0;
    chk("done_count", o_ndone, 1);
  endtask

  vec_t vecs[5];
  txn_t tr;

  initial begin
    vecs[0] = '{t:'{lw:1, ac:0, wb:8'h10, ub:8'h40, ab:8'h80, rows:8'd4},
                done_k:63, first_wacc:59, n_wb:16, n_load:16, n_mm:36, n_wacc:4, last_addra:8'h83};
    vecs[1] = '{t:'{lw:0, ac:1, wb:8'h00, ub:8'h33, ab:8'h55, rows:8'd1},
                done_k:39, first_wacc:38, n_wb:0, n_load:0, n_mm:33, n_wacc:1, last_addra:8'h55};
    vecs[2] = '{t:'{lw:0, ac:0, wb:8'h00, ub:8'hFE, ab:8'hFF, rows:8'd4},
                done_k:42, first_wacc:38, n_wb:0, n_load:0, n_mm:36, n_wacc:4, last_addra:8'h02};
    vecs[3] = '{t:'{lw:1, ac:1, wb:8'hF8, ub:8'h12, ab:8'h34, rows:8'd0},
                done_k:22, first_wacc:0, n_wb:16, n_load:16, n_mm:0, n_wacc:0, last_addra:8'h00};
    vecs[4] = '{t:'{lw:0, ac:1, wb:8'h01, ub:8'h02, ab:8'h03, rows:8'd0},
                done_k:1, first_wacc:0, n_wb:0, n_load:0, n_mm:0, n_wacc:0, last_addra:8'h00};

    reset_n = 1'b0; start = 1'b0; load_w = 1'b0; accumulate = 1'b0;
    wb_base = '0; ub_base = '0; acc_base = '0; rows = '0;
    #12;
    chk("reset_state", act, '0);
    @(negedge clk);
    reset_n = 1'b1;

    foreach (vecs[i]) begin
      run_pass(vecs[i].t, 0, 1'b0);
      chk($sformatf("v%0d_done_k", i), o_done_k, vecs[i].done_k);
      chk($sformatf("v%0d_first_wacc", i), o_first_wacc, vecs[i].first_wacc);
      chk($sformatf("v%0d_n_wb", i), o_nwb, vecs[i].n_wb);
      chk($sformatf("v%0d_n_load", i), o_nload, vecs[i].n_load);
      chk($sformatf("v%0d_n_mm", i), o_nmm, vecs[i].n_mm);
      chk($sformatf("v%0d_n_wacc", i), o_nwacc, vecs[i].n_wacc);
      chk($sformatf("v%0d_last_addra", i), o_last_addra, vecs[i].last_addra);
    end

    // start re-pulsed mid-COMPUTE while the inputs keep changing
    tr = '{lw:1, ac:1, wb:8'h20, ub:8'h60, ab:8'hA0, rows:8'd6};
    run_pass(tr, 24, 1'b1);
    // start re-pulsed in the DONE cycle
    tr = '{lw:0, ac:0, wb:8'h00, ub:8'h07, ab:8'h09, rows:8'd2};
    run_pass(tr, model_done(tr), 1'b0);

    // async reset mid-COMPUTE, then a clean pass
    tr = '{lw:0, ac:1, wb:8'h00, ub:8'h10, ab:8'h20, rows:8'd40};
    launch(tr);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      start = 1'b0;
      chk($sformatf("pre_rst_cyc%0d", k), act, model(k, tr));
    end
    #2 reset_n = 1'b0;
    #1 chk("async_reset_outputs", act, '0);
    @(negedge clk);
    chk("held_reset_outputs", act, '0);
    reset_n = 1'b1;
    run_pass(vecs[0].t, 0, 1'b0);
    chk("post_reset_done_k", o_done_k, 63);

    // randomized passes against the timeline model
    for (int n = 0; n < 14; n++) begin
      tr.lw   = 1'($urandom);
      tr.ac   = 1'($urandom);
      tr.wb   = 8'($urandom);
      tr.ub   = 8'($urandom);
      tr.ab   = 8'($urandom);
      tr.rows = 8'($urandom_range(0, 24));
      run_pass(tr, ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, model_done(tr))) : 0,
               1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
